// File: rtl/stk_pkg.sv
// Shared types for the multi-engine stack controller: engine count, opcodes,
// response status codes and engine id width.
package cfg_pkg;
  localparam int unsigned ENGS_N = 4;
endpackage

package stk_pkg;
  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_INV  = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    STATUS_OKAY  = 2'b00,
    STATUS_EMPTY = 2'b01,
    STATUS_FULL  = 2'b10,
    STATUS_ERR   = 2'b11
  } status_t;

  localparam int unsigned ENGID_W = $clog2(cfg_pkg::ENGS_N);
  typedef logic [ENGID_W-1:0] engid_t;
endpackage

// File: rtl/stk_mstk_ram.sv
// Behavioural single-port synchronous-read RAM; read data holds while en=0.
// Replaced by the SRAM macro at integration.
module stk_mstk_ram #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          wen,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (wen) mem[addr] <= wdata;
      else     rdata     <= mem[addr];
    end
  end
endmodule

// File: rtl/stk_mstk.sv
// Multi-engine LIFO controller over one statically partitioned RAM.
// Optional feature macro: STK_MSTK_INV_CLEAR_EN (INV clears the target engine).
module stk_mstk
  import stk_pkg::*;
#(
  parameter int unsigned ENGS_N        = cfg_pkg::ENGS_N,
  parameter int unsigned W             = 32,
  parameter int unsigned LINES_PER_ENG = 256
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [$clog2(ENGS_N)-1:0] in_engid,
  input  opcode_t                   in_opcode,
  input  logic [W-1:0]              in_data,
  output logic                      rsp_vld,
  input  logic                      rsp_rdy,
  output logic [$clog2(ENGS_N)-1:0] rsp_engid,
  output opcode_t                   rsp_opcode,
  output status_t                   rsp_status,
  output logic [W-1:0]              rsp_data,
  output logic [ENGS_N-1:0]         eng_empty,
  output logic [ENGS_N-1:0]         eng_full
);
  localparam int unsigned EW = $clog2(ENGS_N);
  localparam int unsigned PW = $clog2(LINES_PER_ENG);
  localparam int unsigned DW = $clog2(LINES_PER_ENG + 1);
  localparam int unsigned AW = EW + PW;
  localparam logic [DW-1:0] FULL_D = DW'(LINES_PER_ENG);

  logic [DW-1:0] depth [ENGS_N];
  logic [DW-1:0] cur, nxt_depth;
  logic          accept, depth_we, ram_en, ram_wen, pop_ok, rsp_pop_ok;
  logic [PW-1:0] ptr;
  status_t       nxt_status;
  logic [W-1:0]  ram_rdata;

  assign in_rdy = ~rsp_vld | rsp_rdy;
  assign accept = in_vld & in_rdy;
  assign cur    = depth[in_engid];

  always_comb begin
    depth_we   = 1'b0;
    nxt_depth  = cur;
    ram_en     = 1'b0;
    ram_wen    = 1'b0;
    ptr        = cur[PW-1:0];
    nxt_status = STATUS_OKAY;
    pop_ok     = 1'b0;
    case (in_opcode)
      OP_PUSH: begin
        if (cur < FULL_D) begin
          ram_en    = accept;
          ram_wen   = 1'b1;
          depth_we  = accept;
          nxt_depth = cur + DW'(1);
        end else begin
          nxt_status = STATUS_FULL;
        end
      end
      OP_POP: begin
        ptr = PW'(cur - DW'(1));
        if (cur != '0) begin
          ram_en    = accept;
          depth_we  = accept;
          nxt_depth = cur - DW'(1);
          pop_ok    = 1'b1;
        end else begin
          nxt_status = STATUS_EMPTY;
        end
      end
      OP_INV: begin
`ifdef STK_MSTK_INV_CLEAR_EN
        depth_we  = accept;
        nxt_depth = '0;
`else
        nxt_status = STATUS_ERR;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int unsigned i = 0; i < ENGS_N; i++) depth[i] <= '0;
    end else if (depth_we) begin
      depth[in_engid] <= nxt_depth;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rsp_vld    <= 1'b0;
      rsp_engid  <= '0;
      rsp_opcode <= OP_NOP;
      rsp_status <= STATUS_OKAY;
      rsp_pop_ok <= 1'b0;
    end else if (accept) begin
      rsp_vld    <= 1'b1;
      rsp_engid  <= in_engid;
      rsp_opcode <= in_opcode;
      rsp_status <= nxt_status;
      rsp_pop_ok <= pop_ok;
    end else if (rsp_rdy) begin
      rsp_vld <= 1'b0;
    end
  end

  // RAM output is held while stalled, so pop data needs no extra register.
  assign rsp_data = rsp_pop_ok ? ram_rdata : '0;

  always_comb begin
    eng_empty = '0;
    eng_full  = '0;
    for (int unsigned i = 0; i < ENGS_N; i++) begin
      eng_empty[i] = (depth[i] == '0);
      eng_full[i]  = (depth[i] == FULL_D);
    end
  end

  stk_mstk_ram #(
    .W     (W),
    .DEPTH (ENGS_N * LINES_PER_ENG),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .wen   (ram_wen),
    .addr  ({in_engid, ptr}),
    .wdata (in_data),
    .rdata (ram_rdata)
  );
endmodule

// File: doc/stk_mstk.md
# stk_mstk

Multi-engine stack controller. It is the parametrised successor to the single-stack opcode/pointer scheme. It serves `ENGS_N` independent LIFO stacks from one statically partitioned storage array, with each engine owning `LINES_PER_ENG` lines. Requests use a valid/ready handshake, and responses return with status on a one-entry output stage. It sits between the engine request arbiter and the stack SRAM.

## Interface
Parameters:
- `ENGS_N`, `cfg_pkg::ENGS_N` (4): number of engines/stacks; power of two, ≥2.
- `W`, 32: data word width.
- `LINES_PER_ENG`, 256: lines per engine; power of two, ≤1024.

Ports:
- `clk`: in, 1, clock.
- `arst_n`: in, 1, reset; asynchronous, active-low.
- `in_vld`: in, 1, request valid.
- `in_rdy`: out, 1, request ready.
- `in_engid`: in, `ENGID_W`, target engine.
- `in_opcode`: in, 2, `stk_pkg::opcode_t`.
- `in_data`: in, `W`, push data.
- `rsp_vld`: out, 1, response valid.
- `rsp_rdy`: in, 1, response ready.
- `rsp_engid`: out, `ENGID_W`, echoed engine.
- `rsp_opcode`: out, 2, echoed opcode.
- `rsp_status`: out, 2, `stk_pkg::status_t`.
- `rsp_data`: out, `W`, pop data; 0 for any non-OKAY pop and for all non-pop ops.
- `eng_empty`: out, `ENGS_N`, per-engine depth==0.
- `eng_full`: out, `ENGS_N`, per-engine depth==`LINES_PER_ENG`.

## Operation
- Accept when `in_vld & in_rdy`, where `in_rdy = ~rsp_vld | rsp_rdy`.
- State per engine: a depth counter of `$clog2(LINES_PER_ENG+1)` bits.
- Line address is `{engid, depth_ptr}` with width `ENGID_W + $clog2(LINES_PER_ENG)`.
- PUSH, depth < LINES: write `in_data` at `{e, depth}`; depth+1; status OKAY.
- PUSH, depth == LINES: no write; depth unchanged; status FULL.
- POP, depth > 0: read `{e, depth-1}`; depth-1; status OKAY; `rsp_data` = word read.
- POP, depth == 0: no read; status EMPTY; `rsp_data` = 0.
- NOP: no state change; status OKAY.
- INV: see Configuration.
- Status encoding: OKAY=00, EMPTY=01, FULL=10, ERR=11.
- Depth update, SRAM write and SRAM read enable all occur in the accept cycle.
- A push then a pop to the same engine in consecutive cycles returns the pushed word. The write commits at the edge ending the push cycle, and the read samples after it. No forwarding is needed.
- Different engines never alias.
- `eng_empty` and `eng_full` are decoded from the registered depth counters. They reflect an accept one cycle after it.

## Timing
- Latency: the response is valid in the cycle after accept (1 cycle).
- Throughput: one request per cycle while `rsp_rdy`=1.
- Stall: while `rsp_vld & ~rsp_rdy`, all `rsp_*` outputs are held stable and no request is accepted. The RAM holds its read output when its enable is low.
- Reset (`arst_n`=0, asynchronous):
  - `rsp_vld`=0, `rsp_status`=OKAY, `rsp_data`=0, `rsp_engid`=0, `rsp_opcode`=NOP.
  - All depths = 0, so `eng_empty`=all-ones and `eng_full`=0.
  - `in_rdy`=1.
- Reset mid-operation: a pending response is dropped and stack contents are logically lost. RAM contents are not cleared.
- Deassertion is synchronised externally; the first accept may occur in the first cycle after deassertion.

## Configuration
- `STK_MSTK_INV_CLEAR_EN` defined: INV clears the target engine, setting its depth to 0 with status OKAY. No RAM access. A following pop to that engine returns EMPTY.
- Undefined: INV returns status ERR with no state change.

## Structure
- `stk_pkg` additions:
  - `status_t` with STATUS_EMPTY, STATUS_FULL and STATUS_ERR added.
  - `ENGID_W` and `engid_t` (already present).
- Local to `stk_mstk`: address width and depth width localparams.
- Sub-module `stk_mstk_ram`: single-port, synchronous-read RAM of `ENGS_N*LINES_PER_ENG` × `W`.
  - Inputs: `en`, `wen`, `addr`, `wdata`; output: `rdata`.
  - `rdata` is held when `en`=0.
  - Behavioural model; swapped for the SRAM macro at integration.

## Test plan
- Push `0xA5A5_0001` then pop to engine 1 (back-to-back) -> two responses: OKAY/0, then OKAY/`0xA5A5_0001`; `eng_empty[1]` returns to 1.
- Pop engine 0 out of reset -> EMPTY, `rsp_data`=0, depth stays 0.
- 256 pushes (values 0..255) to engine 2 -> all OKAY and `eng_full[2]`=1. 257th push -> FULL. Then 256 pops return 255..0; the next pop -> EMPTY.
- Interleave pushes 0x10/0x20 to engine 0 and 0x30 to engine 3, then pop engine 0 twice -> 0x20, 0x10. Engine 3 depth stays 1.
- Hold `rsp_rdy`=0 for 5 cycles after a pop -> `in_rdy`=0 and `rsp_*` stable throughout. Release -> accepted traffic resumes at 1/cycle.
- INV to engine 1 holding 3 entries:
  - With the macro: OKAY, then pop -> EMPTY.
  - Without the macro: ERR, then pop -> OKAY with the top word.
